// File: rtl/sha256_thread_sched.sv
// -----------------------------------------------------------------------------
// sha256_thread_sched
//
// Thread scheduler for the SHA-256 crypt engine. Tracks which of the
// 2*N_CORES threads are ready and which cores are occupied. Issues ready
// threads to free cores by walking the engine's fixed interleaved order:
// the core number increments, and the sequence bit toggles when the core
// number wraps around. For N_CORES=3 the order is 0,2,4,1,3,5.
//
// Thread number encoding: {core_num, seq_num}, with seq in the LSB.
//
// Ports
//   CLK         clock; all state changes on the rising edge
//   RST         asynchronous active-high reset
//   ready_set   pulse; bit t marks thread t ready
//   core_done   pulse; bit c frees core c
//   out_valid   an issued thread is presented on out_thread
//   out_thread  issued thread number
//   out_rd      consumer takes out_thread this cycle (when out_valid=1)
//   ready_mask  current ready bits
//   core_busy   current busy bits
//   idle        nothing ready, nothing busy, nothing presented
// -----------------------------------------------------------------------------
module sha256_thread_sched #(
    parameter int N_CORES   = 3,
    parameter int N_THREADS = 2 * N_CORES,
    parameter int TW        = $clog2(N_THREADS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_THREADS-1:0] ready_set,
    input  logic [N_CORES-1:0]   core_done,
    output logic                 out_valid,
    output logic [TW-1:0]        out_thread,
    input  logic                 out_rd,
    output logic [N_THREADS-1:0] ready_mask,
    output logic [N_CORES-1:0]   core_busy,
    output logic                 idle
);

    // Width of the core-number field inside a thread number.
    localparam int CW = TW - 1;

    logic [N_THREADS-1:0] ready_reg;
    logic [N_THREADS-1:0] ready_next;
    logic [N_CORES-1:0]   busy_reg;
    logic [N_CORES-1:0]   busy_next;
    logic [TW-1:0]        ptr_reg;
    logic [TW-1:0]        ptr_next;
    logic                 out_valid_reg;
    logic [TW-1:0]        out_thread_reg;

    logic [CW-1:0]        ptr_core;
    logic                 ptr_seq;
    logic [N_THREADS-1:0] thread_hit;
    logic [N_CORES-1:0]   core_hit;
    logic                 slot_free;
    logic                 issue;

    assign ptr_core = ptr_reg[TW-1:1];
    assign ptr_seq  = ptr_reg[0];

    // One-hot decode of the pointer into thread and core selects.
    genvar gi;
    generate
        for (gi = 0; gi < N_THREADS; gi = gi + 1) begin : g_thread_hit
            assign thread_hit[gi] = (ptr_reg == TW'(gi));
        end
        for (gi = 0; gi < N_CORES; gi = gi + 1) begin : g_core_hit
            assign core_hit[gi] = (ptr_core == CW'(gi));
        end
    endgenerate

    // The output slot can take a new thread when empty or being drained.
    assign slot_free = ~out_valid_reg | out_rd;

    // Decisions look only at registered ready/busy state.
    assign issue = slot_free
                 & (|(ready_reg & thread_hit))
                 & ~(|(busy_reg & core_hit));

    // Fixed interleaved order: step the core, toggle seq on core wrap.
    always_comb begin
        ptr_next = ptr_reg;
        if (ptr_core == CW'(N_CORES - 1)) begin
            ptr_next = {CW'(0), ~ptr_seq};
        end else begin
            ptr_next = {ptr_core + CW'(1), ptr_seq};
        end
    end

    // A set pulse on the thread being issued wins over the issue clear.
    assign ready_next = (ready_reg & ~(thread_hit & {N_THREADS{issue}})) | ready_set;

    // Issue never targets a busy core, so done and issue of one core cannot meet.
    assign busy_next = (busy_reg & ~core_done) | (core_hit & {N_CORES{issue}});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_reg      <= '0;
            busy_reg       <= '0;
            ptr_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_thread_reg <= '0;
        end else begin
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            // While the presented thread is stalled, the pointer and the
            // output hold so the rotation resumes exactly where it stopped.
            if (slot_free) begin
                ptr_reg       <= ptr_next;
                out_valid_reg <= issue;
                if (issue) begin
                    out_thread_reg <= ptr_reg;
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_thread = out_thread_reg;
    assign ready_mask = ready_reg;
    assign core_busy  = busy_reg;
    assign idle       = ~(|ready_reg) & ~(|busy_reg) & ~out_valid_reg;

endmodule
